// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial-pattern detector.
package seq_det_pkg;

  localparam int ST_W = 2;

  // Controller states; encoding is shared with software via state_out.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width needed to hold a pattern length in the range 0..max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_match_shreg.sv
// Bit history, fill tracking and masked pattern compare.
// match is combinational and reflects the values after the current shift.
module seq_match_shreg
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               shift,
  input  logic               bit_in,
  input  logic               clear_fill,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               match
);

  logic [MAX_LEN-1:0] history;
  logic [MAX_LEN-1:0] history_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_next;

  // Next history/fill values and the compare restricted to the low len bits.
  always_comb begin
    history_next = history;
    fill_next    = fill;
    mask         = {MAX_LEN{1'b0}};
    if (shift) begin
      history_next = {history[MAX_LEN-2:0], bit_in};
      if (fill == LEN_W'(MAX_LEN)) begin
        fill_next = fill;
      end else begin
        fill_next = fill + LEN_W'(1);
      end
    end else begin
      history_next = history;
      fill_next    = fill;
    end
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    match = shift && (fill_next >= len) &&
            (((history_next ^ pattern) & mask) == {MAX_LEN{1'b0}});
  end

  // History and fill registers; a non-overlapping match discards used bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history <= {MAX_LEN{1'b0}};
      fill    <= {LEN_W{1'b0}};
    end else if (clear) begin
      history <= {MAX_LEN{1'b0}};
      fill    <= {LEN_W{1'b0}};
    end else if (shift) begin
      history <= history_next;
      fill    <= (match && clear_fill) ? {LEN_W{1'b0}} : fill_next;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial-pattern detection controller: config registers,
// run FSM, saturating match counter and registered status outputs.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               busy,
  output logic               detected,
  output logic               done,
  output logic [CNT_W-1:0]   match_count,
  output logic [ST_W-1:0]    state_out
);

  state_t             state;
  state_t             state_next;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic [CNT_W-1:0]   target;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_inc;
  logic               arm;
  logic               finish;
  logic               shift;
  logic               hit;

  // Bits are only sampled in RUN, and an abort in the same cycle wins.
  assign shift     = (state == ST_RUN) && !abort && bit_valid;
  assign count_inc = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);

  seq_match_shreg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (arm),
    .shift      (shift),
    .bit_in     (bit_in),
    .clear_fill (!overlap),
    .len        (len),
    .pattern    (pattern),
    .match      (hit)
  );

  // Next-state decode: arm on start with a non-empty pattern, stop on target or abort.
  always_comb begin
    state_next = state;
    arm        = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start && !abort && (len != {LEN_W{1'b0}})) begin
          state_next = ST_RUN;
          arm        = 1'b1;
        end else begin
          state_next = state;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (hit && (target != {CNT_W{1'b0}}) && (count_inc == target)) begin
          state_next = ST_DONE;
          finish     = 1'b1;
        end else begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Config registers load only while not running; length is clamped to MAX_LEN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= {MAX_LEN{1'b0}};
      len     <= {LEN_W{1'b0}};
      overlap <= 1'b0;
      target  <= {CNT_W{1'b0}};
    end else if (cfg_we && ((state == ST_IDLE) || (state == ST_DONE))) begin
      pattern <= cfg_pattern;
      len     <= (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      overlap <= cfg_overlap;
      target  <= cfg_target;
    end
  end

  // Match counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= {CNT_W{1'b0}};
      detected <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (arm) begin
        count <= {CNT_W{1'b0}};
      end else if (hit) begin
        count <= count_inc;
      end
      detected <= hit;
      done     <= finish;
      busy     <= (state_next == ST_RUN);
    end
  end

  assign match_count = count;
  assign state_out   = state;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus a random
// run, all compared against a bit-list reference model.
module tb_seq_det_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               abort;
  logic               bit_valid;
  logic               bit_in;
  logic               busy;
  logic               detected;
  logic               done;
  logic [CNT_W-1:0]   match_count;
  logic [1:0]         state_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the bits received since the run was armed.
  logic [1:0]         m_state;
  int                 m_count;
  bit                 m_bits[$];
  int                 m_base;
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  int                 m_tgt;
  logic               e_det;
  logic               e_done;

  logic [CNT_W+4:0] obs;
  assign obs = {busy, detected, done, state_out, match_count};

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in),
    .busy(busy), .detected(detected), .done(done),
    .match_count(match_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W+4:0] expect_vec();
    return {m_state == S_RUN, e_det, e_done, m_state, CNT_W'(m_count)};
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_count = 0; m_bits.delete(); m_base = 0;
    m_pat = '0; m_len = 0; m_ovl = 1'b0; m_tgt = 0;
    e_det = 1'b0; e_done = 1'b0;
  endtask

  task automatic model_cycle(input logic s, input logic a, input logic v,
                             input logic b, input logic w);
    int sz;
    bit ok;
    e_det  = 1'b0;
    e_done = 1'b0;
    if (m_state == S_RUN) begin
      if (a) begin
        m_state = S_IDLE;
      end else if (v) begin
        m_bits.push_back(b);
        sz = m_bits.size();
        ok = (sz - m_base) >= m_len;
        if (ok) begin
          for (int k = 0; k < m_len; k++) begin
            if (m_bits[sz-1-k] != m_pat[k]) ok = 1'b0;
          end
        end
        if (ok) begin
          if (m_count < CMAX) m_count++;
          e_det = 1'b1;
          if (!m_ovl) m_base = sz;
          if (m_tgt != 0 && m_count == m_tgt) begin
            e_done  = 1'b1;
            m_state = S_DONE;
          end
        end
      end
    end else begin
      if (s && !a && m_len != 0) begin
        m_state = S_RUN; m_count = 0; m_bits.delete(); m_base = 0;
      end
      if (w) begin
        m_pat = cfg_pattern;
        m_len = (cfg_len > MAX_LEN) ? MAX_LEN : int'(cfg_len);
        m_ovl = cfg_overlap;
        m_tgt = cfg_target;
      end
    end
  endtask

  // One clock with the given controls, then advance the model.
  task automatic tick(input logic s, input logic a, input logic v,
                      input logic b, input logic w);
    start = s; abort = a; bit_valid = v; bit_in = b; cfg_we = w;
    @(posedge clk);
    #1;
    model_cycle(s, a, v, b, w);
    start = 1'b0; abort = 1'b0; bit_valid = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic set_cfg(input logic [MAX_LEN-1:0] p, input int l,
                         input logic o, input int t);
    cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = o; cfg_target = CNT_W'(t);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_target = '0; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs !== expect_vec() || state_out !== S_IDLE) begin
      n_fail++; $display("FAIL reset_start_len0: got %h expected %h", obs, expect_vec());
    end
  endtask

  task automatic test_nonoverlap();
    int stream[5] = '{1, 0, 1, 0, 1};
    set_cfg(8'b101, 3, 1'b0, 0);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b1, stream[i][0], 1'b0);
      n_checks++;
      if (obs !== expect_vec() || detected !== (i == 2)) begin
        n_fail++; $display("FAIL nonoverlap_bit%0d: got %h expected %h", i, obs, expect_vec());
      end
    end
    n_checks++;
    if (match_count !== 8'd1) begin
      n_fail++; $display("FAIL nonoverlap_count: got %0d expected 1", match_count);
    end
  endtask

  task automatic test_overlap();
    int stream[5] = '{1, 0, 1, 0, 1};
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(8'b101, 3, 1'b1, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b1, stream[i][0], 1'b0);
      n_checks++;
      if (obs !== expect_vec() || detected !== (i == 2 || i == 4)) begin
        n_fail++; $display("FAIL overlap_bit%0d: got %h expected %h", i, obs, expect_vec());
      end
    end
    n_checks++;
    if (match_count !== 8'd2) begin
      n_fail++; $display("FAIL overlap_count: got %0d expected 2", match_count);
    end
  endtask

  task automatic test_target();
    logic [15:0] stream = 16'hA5A5;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(8'hA5, 8, 1'b0, 2);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 15; i >= 0; i--) begin
      tick(1'b0, 1'b0, 1'b1, stream[i], 1'b0);
      n_checks++;
      if (obs !== expect_vec()) begin
        n_fail++; $display("FAIL target_bit%0d: got %h expected %h", 15 - i, obs, expect_vec());
      end
    end
    n_checks++;
    if ({busy, detected, done, state_out, match_count} !== {3'b011, S_DONE, 8'd2}) begin
      n_fail++; $display("FAIL target_done: got %h expected %h", obs, {3'b011, S_DONE, 8'd2});
    end
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs !== expect_vec() || state_out !== S_DONE || match_count !== 8'd2) begin
      n_fail++; $display("FAIL target_trailing: got %h expected %h", obs, expect_vec());
    end
  endtask

  task automatic test_abort();
    int pre[6] = '{1, 0, 1, 1, 1, 0};
    set_cfg(8'b1011, 4, 1'b0, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b1, pre[i][0], 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs !== expect_vec() || state_out !== S_IDLE || match_count !== 8'd1) begin
      n_fail++; $display("FAIL abort_hold: got %h expected %h", obs, expect_vec());
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== expect_vec() || match_count !== 8'd0) begin
      n_fail++; $display("FAIL abort_restart: got %h expected %h", obs, expect_vec());
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (obs !== expect_vec() || detected !== 1'b0) begin
        n_fail++; $display("FAIL abort_suffix%0d: got %h expected %h", i, obs, expect_vec());
      end
    end
  endtask

  task automatic test_cfg_in_run();
    int tail[4] = '{1, 1, 0, 1};
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(8'b101, 3, 1'b0, 1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_cfg(8'b11, 2, 1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b1, tail[i][0], 1'b0);
      n_checks++;
      if (obs !== expect_vec() || detected !== (i == 3)) begin
        n_fail++; $display("FAIL cfg_run_bit%0d: got %h expected %h", i, obs, expect_vec());
      end
    end
    set_cfg(8'b11, 2, 1'b0, 1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs !== expect_vec() || {detected, done, state_out} !== {2'b11, S_DONE}) begin
      n_fail++; $display("FAIL cfg_done_new: got %h expected %h", obs, expect_vec());
    end
  endtask

  task automatic test_len0_and_reset();
    set_cfg(8'b101, 3, 1'b0, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_cfg(8'b0, 0, 1'b0, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== expect_vec() || state_out !== S_IDLE || busy !== 1'b0) begin
      n_fail++; $display("FAIL len0_start: got %h expected %h", obs, expect_vec());
    end
    set_cfg(8'b101, 3, 1'b0, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (obs !== expect_vec() || state_out !== S_IDLE) begin
      n_fail++; $display("FAIL start_abort: got %h expected %h", obs, expect_vec());
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL async_reset: got %h expected 0", obs);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== expect_vec() || state_out !== S_IDLE) begin
      n_fail++; $display("FAIL reset_clears_cfg: got %h expected %h", obs, expect_vec());
    end
  endtask

  task automatic test_random();
    logic s, a, v, b, w;
    int errs = 0;
    for (int c = 0; c < 3000; c++) begin
      w = ($urandom_range(0, 7) == 0);
      if (w) begin
        cfg_pattern = MAX_LEN'($urandom);
        cfg_len     = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 15))
                                                  : LEN_W'($urandom_range(1, 4));
        cfg_overlap = 1'($urandom_range(0, 1));
        cfg_target  = CNT_W'($urandom_range(0, 4));
      end
      s = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      b = 1'($urandom_range(0, 1));
      tick(s, a, v, b, w);
      n_checks++;
      if (obs !== expect_vec()) begin
        n_fail++;
        if (errs < 10) $display("FAIL random_cycle%0d: got %h expected %h", c, obs, expect_vec());
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonoverlap();
    test_overlap();
    test_target();
    test_abort();
    test_cfg_in_run();
    test_len0_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
